fp_csub_pipe: RTL
=================

Name: fp_csub_pipe

Overview:
Parametrised two-stage pipelined unsigned floating-point "constant minus x" unit. Generalises the fixed 1.5 − x stage of the inverse-square-root Newton step to any constant and any exponent/mantissa width. Adds:
- sideband delay channel of configurable width
- upstream stall output and full stall propagation
- negative-result detection folded into the error chain

Sits between the multiply stages of the InvSqrt datapath.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width (hidden bit implicit)
GRD_W, 3, guard bits carried through alignment (last bit is sticky)
C_EXP, 127, biased exponent of constant C
C_MAN, 23'h400000, mantissa of C (default C = 1.5)
SIDE_W, 31, sideband (delayed operand) width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
valid  in  1  input word valid
float_in  in  EXP_W+MAN_W  operand x, unsigned float {exp, man}
side_in  in  SIDE_W  sideband carried alongside x
error_in  in  1  upstream error flag
stall_out  out  1  high: input not accepted this cycle
backprn  in  1  downstream backpressure, high = hold output
float_out  out  EXP_W+MAN_W  C − x
side_out  out  SIDE_W  side_in delayed with its result
ready  out  1  output word valid
error_out  out  1  error_in OR negative-result flag

Behaviour:
- Reset (rstn low, asynchronous): all stage valids, ready, error_out, float_out and side_out go to 0. Reset mid-operation discards in-flight words.
- Stage 1, align/subtract:
  - if exp(x)==0, x = 0 (denormals flushed)
  - if x > C (exp greater, or exp equal and man greater), set neg flag and force difference 0
  - else shift d = C_EXP − exp(x)
  - x_al = {1, man, GRD_W zeros} >> d, shifted-out bits ORed into LSB
  - if d > MAN_W+GRD_W, x_al = sticky only
  - diff = {1, C_MAN, 0} − x_al, width MAN_W+GRD_W+1
- Stage 2, normalise:
  - lz = leading-zero count of diff
  - if diff == 0, result 0
  - else exponent = C_EXP − lz; if that is ≤ 0, flush result to 0 with no error
  - mantissa = (diff << lz), hidden bit and guard bits dropped (truncate)
  - error_out = error_in OR neg; neg result outputs 0
- Handshake:
  - stage k loads when empty or stage k+1 (or the output with backprn low) drains it
  - stall_out = stage1 full AND stage1 cannot advance
  - valid while stall_out is high is ignored; upstream holds data
  - output regs hold value and ready while backprn is high
  - no bubbles, no drops, order preserved
- Latency 2 cycles from accepted valid to ready with backprn low. Throughput 1 word/cycle.
- side_in and error_in travel in lockstep with their operand through both stages.

Optional Feature:
FP_CSUB_RNE_EN
- Defined: stage 2 rounds to nearest-even using the guard bits (guard, round, sticky). A mantissa carry-out increments the exponent and clears the mantissa.
- Undefined: truncation; guard bits discarded. Latency is unchanged in both modes.

Decomposition:
- Package fp_csub_pkg holds:
  - FLT_W = EXP_W+MAN_W
  - SIG_W = MAN_W+GRD_W+1
  - stage-1 payload struct {diff, neg, err, side}
  - default constant for 1.5
- One natural sub-module, fp_csub_norm: leading-zero count, shift, exponent adjust and rounding. Combinational; registered by the parent.

Test Plan:
- x=0x3F800000 (1.0), defaults, backprn=0: ready 2 cycles after valid with float_out=0x3F000000 (0.5), error_out=0.
- x=0x3F000000 → 0x3F800000; x=0x3FC00000 → 0x00000000, error_out=0; x=0x00000000 → 0x3FC00000.
- x=0x40000000 (2.0) → float_out=0, error_out=1; error_in=1 with x=1.0 → 0x3F000000, error_out=1.
- x=0x33000000 (2^-25): without FP_CSUB_RNE_EN → 0x3FBFFFFF; with it → 0x3FC00000.
- Stream 6 words back-to-back, backprn high cycles 3–5:
  - stall_out asserts while both stages are full
  - outputs held stable
  - all 6 results appear in order, side_out matching each side_in
- Assert rstn low with 2 words in flight: ready, error_out, float_out drop to 0 immediately (asynchronously); the next accepted word yields a correct result 2 cycles later.

Source files
------------

// File: rtl/fp_csub_pkg.sv
// rtl/fp_csub_pkg.sv - shared widths, defaults and stage-1 payload type for fp_csub_pipe
package fp_csub_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MAN_W  = 23;
  localparam int DEF_GRD_W  = 3;
  localparam int DEF_SIDE_W = 31;

  localparam int FLT_W = DEF_EXP_W + DEF_MAN_W;
  localparam int SIG_W = DEF_MAN_W + DEF_GRD_W + 1;

  // Constant C = 1.5 in the default format
  localparam int                    C15_EXP = 127;
  localparam logic [DEF_MAN_W-1:0]  C15_MAN = 23'h400000;

  // Stage-1 payload for the default configuration
  typedef struct packed {
    logic [SIG_W-1:0]      diff;
    logic                  neg;
    logic                  err;
    logic [DEF_SIDE_W-1:0] side;
  } s1_payload_t;

  function automatic int flt_w(input int exp_w, input int man_w);
    return exp_w + man_w;
  endfunction

  function automatic int sig_w(input int man_w, input int grd_w);
    return man_w + grd_w + 1;
  endfunction

endpackage

// File: rtl/fp_csub_norm.sv
// rtl/fp_csub_norm.sv - combinational normaliser: leading-zero count, shift, exponent adjust, rounding
// Build option: FP_CSUB_RNE_EN selects round-to-nearest-even; otherwise the guard bits are truncated.
module fp_csub_norm
  import fp_csub_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int GRD_W = DEF_GRD_W,
  parameter int C_EXP = C15_EXP
) (
  input  logic [MAN_W+GRD_W:0]   diff_i,
  output logic [EXP_W+MAN_W-1:0] res_o
);

  localparam int S_W  = sig_w(MAN_W, GRD_W);
  localparam int LZ_W = $clog2(S_W + 1);
  localparam int E_W  = EXP_W + 2;

  logic [LZ_W-1:0]  lz;
  logic [S_W-1:0]   norm;
  logic [E_W-1:0]   e_ext;
  logic [MAN_W-1:0] man_t;
  logic [MAN_W-1:0] man_r;
  logic [EXP_W-1:0] exp_r;
  logic             flush;
  logic             unused_bits;

  // Leading-zero count: scanning upward, the highest set bit determines lz
  always_comb begin
    lz = LZ_W'(S_W);
    for (int i = 0; i < S_W; i++) begin
      if (diff_i[i]) lz = LZ_W'(S_W - 1 - i);
    end
  end

  // Hidden bit lands at the MSB; the result exponent is the constant's minus the shift.
  // The extra top bit of e_ext is a borrow, flagging an exponent at or below zero.
  assign norm  = diff_i << lz;
  assign e_ext = E_W'(C_EXP) - E_W'(lz);
  assign flush = (diff_i == '0) || e_ext[E_W-1] || (e_ext == '0);
  assign man_t = norm[S_W-2:GRD_W];

`ifdef FP_CSUB_RNE_EN
  logic             guard;
  logic             rest;
  logic             rnd_up;
  logic [MAN_W:0]   man_inc;

  assign guard   = norm[GRD_W-1];
  assign rest    = |norm[GRD_W-2:0];
  assign rnd_up  = guard & (rest | man_t[0]);
  assign man_inc = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd_up};
  // A carry out of the mantissa leaves it all zeros and bumps the exponent
  assign man_r   = man_inc[MAN_W-1:0];
  assign exp_r   = e_ext[EXP_W-1:0] + {{(EXP_W-1){1'b0}}, man_inc[MAN_W]};
  assign unused_bits = norm[S_W-1] ^ e_ext[EXP_W];
`else
  assign man_r   = man_t;
  assign exp_r   = e_ext[EXP_W-1:0];
  assign unused_bits = norm[S_W-1] ^ e_ext[EXP_W] ^ (^norm[GRD_W-1:0]);
`endif

  assign res_o = flush ? '0 : {exp_r, man_r};

endmodule

// File: rtl/fp_csub_pipe.sv
// rtl/fp_csub_pipe.sv - two-stage pipelined unsigned float C - x with sideband, stall and error chain
// Build option: FP_CSUB_RNE_EN enables round-to-nearest-even in the normalise stage.
module fp_csub_pipe
  import fp_csub_pkg::*;
#(
  parameter int               EXP_W  = DEF_EXP_W,
  parameter int               MAN_W  = DEF_MAN_W,
  parameter int               GRD_W  = DEF_GRD_W,
  parameter int               C_EXP  = C15_EXP,
  parameter logic [MAN_W-1:0] C_MAN  = C15_MAN,
  parameter int               SIDE_W = DEF_SIDE_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid,
  input  logic [EXP_W+MAN_W-1:0] float_in,
  input  logic [SIDE_W-1:0]      side_in,
  input  logic                   error_in,
  output logic                   stall_out,
  input  logic                   backprn,
  output logic [EXP_W+MAN_W-1:0] float_out,
  output logic [SIDE_W-1:0]      side_out,
  output logic                   ready,
  output logic                   error_out
);

  localparam int F_W = flt_w(EXP_W, MAN_W);
  localparam int S_W = sig_w(MAN_W, GRD_W);

  localparam logic [EXP_W-1:0] CE     = EXP_W'(C_EXP);
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + GRD_W);
  localparam logic [S_W-1:0]   C_SIG  = {1'b1, C_MAN, {GRD_W{1'b0}}};

  typedef struct packed {
    logic [S_W-1:0]    diff;
    logic              neg;
    logic              err;
    logic [SIDE_W-1:0] side;
  } s1_t;

  logic [EXP_W-1:0] x_exp;
  logic [MAN_W-1:0] x_man;
  logic             x_zero;
  logic             x_gt;
  logic [EXP_W-1:0] sh;
  logic [S_W-1:0]   x_sig;
  logic [S_W-1:0]   x_al;
  logic             lost;

  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_v_q;

  logic [F_W-1:0]    norm_res;
  logic              out_drain;
  logic              ready_q;
  logic              err_q;
  logic [F_W-1:0]    float_q;
  logic [SIDE_W-1:0] side_q;

  assign x_exp = float_in[F_W-1:MAN_W];
  assign x_man = float_in[MAN_W-1:0];

  // Stage 1 datapath: flush denormals, detect x > C, align x to C's exponent with sticky, subtract
  always_comb begin
    s1_d   = '0;
    x_zero = (x_exp == '0);
    x_gt   = !x_zero && ((x_exp > CE) || ((x_exp == CE) && (x_man > C_MAN)));
    sh     = CE - x_exp;
    x_sig  = {1'b1, x_man, {GRD_W{1'b0}}};
    lost   = |(x_sig & ~({S_W{1'b1}} << sh));
    x_al   = '0;
    if (!x_zero) begin
      if (sh > SH_MAX) x_al = {{(S_W-1){1'b0}}, 1'b1};
      else             x_al = (x_sig >> sh) | {{(S_W-1){1'b0}}, lost};
    end
    s1_d.diff = x_gt ? '0 : C_SIG - x_al;
    s1_d.neg  = x_gt;
    s1_d.err  = error_in;
    s1_d.side = side_in;
  end

  // The output register frees up when it is empty or its word is taken this cycle
  assign out_drain = !ready_q || !backprn;
  assign stall_out = s1_v_q && !out_drain;

  // Stage 1 register: loads whenever it is empty or can pass its word forward
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
    end else if (!stall_out) begin
      s1_v_q <= valid;
      if (valid) s1_q <= s1_d;
    end
  end

  fp_csub_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .GRD_W (GRD_W),
    .C_EXP (C_EXP)
  ) u_norm (
    .diff_i (s1_q.diff),
    .res_o  (norm_res)
  );

  // Stage 2 / output register: holds its word while downstream applies backpressure
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      float_q <= '0;
      side_q  <= '0;
    end else if (out_drain) begin
      ready_q <= s1_v_q;
      if (s1_v_q) begin
        float_q <= s1_q.neg ? '0 : norm_res;
        side_q  <= s1_q.side;
        err_q   <= s1_q.err | s1_q.neg;
      end
    end
  end

  assign ready     = ready_q;
  assign error_out = err_q;
  assign float_out = float_q;
  assign side_out  = side_q;

endmodule
